write_asmd: RTL
===============

# write_asmd

Row-write controller for the matrix-multiplication datapath, the write-side counterpart of the row reader. It accepts a stream of half-words over a valid/ready handshake, lower half first, then upper half. It packs each pair into one full memory word and writes 16 consecutive words to the row at `{base_addr, counter}`. It sits between the result/loader stream and the 512-entry result memory write port.

## Interface
- `DATA_W`, default 16: half-word width; memory word is `2*DATA_W`.
- `ROW_W`, default 5: row (base) address width.
- `COL_W`, default 4: column counter width; words per row = `2**COL_W` (16).
- `clk`  input  1: clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `in_addr`  input  `ROW_W`: row base address; sampled only when a row starts.
- `write_en`  input  1: start request; honoured only in IDLE.
- `in_valid`  input  1: `in_data` holds a valid half-word.
- `in_data`  input  `DATA_W`: half-word, lower then upper alternately.
- `in_ready`  output  1: block accepts a half-word this cycle.
- `wr_en`  output  1: memory write strobe, one cycle per word.
- `wr_addr`  output  `ROW_W+COL_W`: `{base_addr, counter}` of the word being written.
- `wr_data`  output  `2*DATA_W`: `{upper, lower}` packed word.
- `busy`  output  1: high in LOWER or UPPER.
- `done`  output  1: one-cycle pulse coincident with the row's final `wr_en`.

## Operation
- States: IDLE, LOWER, UPPER.
- IDLE: `in_ready`=0. On `write_en`=1, latch `base_addr`<=`in_addr` and `counter`<=0, then go to LOWER.
- LOWER: `in_ready`=1. On `in_valid`=1, capture `lower_q`<=`in_data` and go to UPPER. Otherwise hold.
- UPPER: `in_ready`=1. On `in_valid`=1, register `wr_data`<=`{in_data, lower_q}`, `wr_addr`<=`{base_addr, counter}`, `wr_en`<=1.
  - If `counter`==15: register `done`<=1 and go to IDLE.
  - Otherwise: `counter`<=`counter`+1 and go to LOWER.
- A handshake occurs only when `in_valid` and `in_ready` are both 1. `in_valid` with `in_ready`=0 (IDLE) is ignored and consumes nothing.
- `write_en` outside IDLE is ignored. `in_addr` changes after the start do not affect the row.
- `counter` is `COL_W` bits and never wraps within a row; the row ends at 15.
- `wr_en` and `done` are registered and default to 0 every cycle unless set as above.
- `wr_addr`/`wr_data` hold their last value when `wr_en`=0.
- `busy` and `in_ready` are decoded from state.

## Timing
- Reset values: state IDLE, `counter`=0, `base_addr`=0, `lower_q`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `done`=0, `busy`=0, `in_ready`=0.
- Reset mid-row: immediate return to IDLE. The partial row is abandoned, and no further `wr_en` or `done` is issued.
- Start latency: `write_en` at cycle 0 gives `in_ready`=1 from cycle 1.
- Write latency: `wr_en` rises exactly one cycle after the upper-half handshake.
- Full-rate row (`in_valid` held high): 32 handshakes in cycles 1..32. `wr_en` is high in cycles 3,5,...,33 (16 pulses). `done` and the last `wr_en` are in cycle 33, and state is IDLE in cycle 33.
- Back-to-back rows: `write_en`=1 in the `done` cycle is accepted, and the next row's `in_ready` is high the following cycle.
- Stalls: `in_valid`=0 in LOWER or UPPER holds state, counter and `lower_q`.
- Simultaneous `rst` and any input: reset wins.

## Test plan
- Full-rate row: `in_addr`=5'd3, halves k*2 / k*2+1 for k=0..15.
  - Expect 16 writes to addresses 48..63 with `wr_data`={2k+1, 2k}.
  - `done` only on the write to 63, 33 cycles after start.
- Random stalls: `in_valid` toggled pseudo-randomly, `in_addr`=31.
  - Expect the same data to addresses 496..511, exactly 16 `wr_en`, and no duplicate or dropped words.
- Ignored inputs:
  - `in_valid`=1 in IDLE: no write.
  - `write_en` pulsed and `in_addr` changed mid-row: row address is unchanged.
- Back-to-back: second `write_en` (`in_addr`=7) in the `done` cycle of row 6.
  - Expect the writes to 112..127 to start without an idle gap beyond one cycle.
- Reset mid-row: assert `rst` after the 5th write.
  - Expect all outputs to go to 0 asynchronously with no further writes.
  - A new row afterwards starts at counter 0.
- Boundary: row 0 with `in_data` 16'hFFFF/16'h0000.
  - `wr_addr` 0..15, `wr_data`=32'h0000FFFF.
  - `counter` ends the row at 15 without wrapping to address 0 of the next row.

Source files
------------

// File: rtl/write_asmd_if.sv
// Half-word stream in, packed memory-word write port out, for the row-write controller.
interface write_asmd_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ROW_W  = 5,
    parameter int unsigned COL_W  = 4
);
    logic [ROW_W-1:0]       in_addr;
    logic                   write_en;
    logic                   in_valid;
    logic [DATA_W-1:0]      in_data;
    logic                   in_ready;
    logic                   wr_en;
    logic [ROW_W+COL_W-1:0] wr_addr;
    logic [2*DATA_W-1:0]    wr_data;
    logic                   busy;
    logic                   done;

    modport master (
        output in_addr, write_en, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  in_addr, write_en, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/write_asmd.sv
// Row-write controller: packs lower/upper half-word pairs into full words and
// writes one row of 2**COL_W consecutive words at {base_addr, counter}.
module write_asmd #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ROW_W  = 5,
    parameter int unsigned COL_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    write_asmd_if.slave        bus
);
    localparam int unsigned ADDR_W = ROW_W + COL_W;
    localparam int unsigned WORD_W = 2 * DATA_W;
    localparam logic [COL_W-1:0] COL_LAST = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOWER = 2'd1,
        UPPER = 2'd2
    } state_t;

    state_t              state_q;
    logic [ROW_W-1:0]    base_q;
    logic [COL_W-1:0]    counter_q;
    logic [DATA_W-1:0]   lower_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [WORD_W-1:0]   wr_data_q;
    logic                done_q;

    // Strobes default low each cycle; address/data hold between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            counter_q <= '0;
            lower_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.write_en) begin
                        base_q    <= bus.in_addr;
                        counter_q <= '0;
                        state_q   <= LOWER;
                    end
                end
                LOWER: begin
                    if (bus.in_valid) begin
                        lower_q <= bus.in_data;
                        state_q <= UPPER;
                    end
                end
                UPPER: begin
                    if (bus.in_valid) begin
                        wr_data_q <= {bus.in_data, lower_q};
                        wr_addr_q <= {base_q, counter_q};
                        wr_en_q   <= 1'b1;
                        // Last column closes the row instead of wrapping.
                        if (counter_q == COL_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            counter_q <= counter_q + COL_W'(1);
                            state_q   <= LOWER;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = (state_q == LOWER) || (state_q == UPPER);
    assign bus.busy     = (state_q == LOWER) || (state_q == UPPER);
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.done     = done_q;
endmodule
